// File: rtl/wb_pkg.sv
// Shared types and defaults for the pipelined Wishbone master.
package wb_pkg;
  localparam int WB_MAX_OUTSTANDING = 4;
  localparam int WB_TIMEOUT_CYCLES  = 255;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } wb_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } wb_rsp_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} wb_mst_state_t;
endpackage

// File: rtl/wishbone_if.sv
// Pipelined (B4) Wishbone bus bundle with master and slave views.
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        lock;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        rty;
  logic        stall;

  modport MASTER (output cyc, stb, we, lock, addr, sel, wdata,
                  input  rdata, ack, err, rty, stall);
  modport SLAVE  (input  cyc, stb, we, lock, addr, sel, wdata,
                  output rdata, ack, err, rty, stall);
endinterface

// File: rtl/wb_pipelined_master.sv
// Valid/ready request channel to pipelined Wishbone master with in-order responses.
// Define WB_TIMEOUT_EN to add the bus timeout timer and FLUSH recovery.
module wb_pipelined_master
  import wb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = WB_MAX_OUTSTANDING
`ifdef WB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
`endif
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  wishbone_if.MASTER  wb_if
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  wb_mst_state_t    state, state_next;
  wb_req_t          req_q;
  wb_rsp_t          rsp_q;
  logic             stb_q, stb_next, rsp_vld_q;
  logic [CW-1:0]    cnt, cnt_next;
  logic [2**CW-1:0] pend_we, pend_we_next;
  logic             flush, timeout, term, push, pop;

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;

  assign flush   = (state == FLUSH);
  assign timeout = (state == ACTIVE) && (cnt != '0) && !term && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                   timer <= '0;
    else if (cnt == '0 || term || state != ACTIVE) timer <= '0;
    else                                           timer <= timer + 1'b1;
  end
`else
  assign flush   = 1'b0;
  assign timeout = 1'b0;
`endif

  // Terminations with nothing outstanding are not ours and are dropped.
  assign term        = (wb_if.ack | wb_if.err | wb_if.rty) && (cnt != '0) && !flush;
  assign req_ready_o = (!stb_q || !wb_if.stall) && (cnt < MAX_CNT) && !flush;
  assign push        = req_valid_i && req_ready_o;
  assign pop         = term || (flush && cnt != '0);
  assign stb_next    = push ? 1'b1 : (!flush && stb_q && wb_if.stall);

  // pend_we[0] is the direction of the oldest outstanding transaction.
  always_comb begin
    cnt_next     = cnt;
    pend_we_next = pend_we;
    if (pop) pend_we_next = pend_we >> 1;
    if (push && !pop) begin
      cnt_next              = cnt + 1'b1;
      pend_we_next[cnt]     = req_we_i;
    end else if (push && pop) begin
      pend_we_next[cnt - 1'b1] = req_we_i;
    end else if (pop) begin
      cnt_next = cnt - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (push) state_next = ACTIVE;
      ACTIVE: begin
        if (timeout)                              state_next = FLUSH;
        else if (cnt_next == '0 && !stb_next)     state_next = IDLE;
      end
`ifdef WB_TIMEOUT_EN
      FLUSH:   if (cnt_next == '0) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stb_q   <= 1'b0;
      req_q   <= '0;
      cnt     <= '0;
      pend_we <= '0;
    end else begin
      stb_q   <= stb_next;
      cnt     <= cnt_next;
      pend_we <= pend_we_next;
      if (push) req_q <= '{we: req_we_i, addr: req_addr_i, sel: req_sel_i, wdata: req_wdata_i};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      rsp_vld_q <= pop;
      if (pop) begin
        rsp_q.err   <= flush | wb_if.err | wb_if.rty;
        rsp_q.rdata <= (!flush && wb_if.ack && !pend_we[0]) ? wb_if.rdata : '0;
      end
    end
  end

  assign wb_if.cyc   = (stb_q || cnt != '0) && !flush;
  assign wb_if.stb   = stb_q && !flush;
  assign wb_if.we    = req_q.we;
  assign wb_if.addr  = req_q.addr;
  assign wb_if.sel   = req_q.sel;
  assign wb_if.wdata = req_q.wdata;
  assign wb_if.lock  = 1'b0;

  assign rsp_valid_o = rsp_vld_q;
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;
endmodule

// File: tb/tb_wb_pipelined_master.sv
// Scoreboard bench for wb_pipelined_master with a scripted pipelined Wishbone slave.
module tb_wb_pipelined_master;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  wishbone_if wb();

  wb_pipelined_master #(
    .MAX_OUTSTANDING(4)
`ifdef WB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_sel_i(req_sel), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .wb_if(wb)
  );

  always #5 clk = ~clk;

  // kind: 0 ack, 1 err, 2 rty, 3 never terminate
  typedef struct { int kind; logic [31:0] rdata; } plan_t;
  typedef struct { int due; int kind; logic [31:0] rdata; } pend_t;
  typedef struct { logic err; logic chk; logic [31:0] rdata; } exp_t;

  plan_t plan_q[$];
  pend_t slv_q[$];
  exp_t  exp_q[$];
  int    issue_log[$];
  int    rsp_log[$];

  int errors = 0, checks = 0;
  int scyc = 0, mcyc = 0;
  int slv_delay = 2;
  int stall_idx = -1, stall_len = 0, stall_done = 0, stall_total = 0, stall_moves = 0;
  int issue_cnt = 0, rsp_seen = 0, cnt_peak = 0;
  int cyc_rise = -1, cyc_fall = -1;
  logic [68:0] stall_snap;
  logic term_flag = 1'b0, spurious = 1'b0;
  bit   check_lat = 1'b1;
  plan_t sp;
  pend_t hp;
  exp_t  me;

  // Slave: updates 1ns after negedge, so outputs are stable for the next posedge.
  initial begin
    wb.ack = 0; wb.err = 0; wb.rty = 0; wb.stall = 0; wb.rdata = '0;
    forever begin
      @(negedge clk); #1;
      scyc++;
      wb.ack = 0; wb.err = 0; wb.rty = 0; wb.rdata = '0; term_flag = 0;
      if (rstn !== 1'b1) begin
        slv_q.delete();
        wb.stall = 0;
      end else begin
        wb.stall = 0;
        if (issue_cnt != stall_idx) stall_done = 0;
        if (wb.cyc && wb.stb && issue_cnt == stall_idx && stall_done < stall_len) begin
          wb.stall = 1;
          if (stall_done == 0) stall_snap = {wb.we, wb.addr, wb.sel, wb.wdata};
          else if (stall_snap !== {wb.we, wb.addr, wb.sel, wb.wdata}) stall_moves++;
          stall_done++;
          stall_total++;
        end
        if (wb.cyc && wb.stb && !wb.stall) begin
          if (issue_cnt == stall_idx && stall_done > 0 && stall_snap !== {wb.we, wb.addr, wb.sel, wb.wdata})
            stall_moves++;
          if (plan_q.size() != 0) sp = plan_q.pop_front();
          else sp = '{3, 32'h0};
          slv_q.push_back('{scyc + slv_delay, sp.kind, sp.rdata});
          issue_cnt++;
          issue_log.push_back(scyc);
        end
        if (spurious) begin
          wb.ack = 1;
        end else if (slv_q.size() != 0 && slv_q[0].due <= scyc && slv_q[0].kind != 3) begin
          hp = slv_q.pop_front();
          wb.rdata  = hp.rdata;
          term_flag = 1;
          case (hp.kind)
            0:       wb.ack = 1;
            1:       wb.err = 1;
            default: wb.rty = 1;
          endcase
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid_o pulse.
  initial begin
    forever begin
      @(negedge clk);
      mcyc++;
      if (rstn === 1'b1) begin
        if (int'(dut.cnt) > cnt_peak) cnt_peak = int'(dut.cnt);
        if (wb.cyc === 1'b1 && cyc_rise < 0) cyc_rise = mcyc;
        if (wb.cyc === 1'b0 && cyc_rise >= 0 && cyc_fall < 0) cyc_fall = mcyc;
        if (check_lat && (term_flag || rsp_valid === 1'b1)) begin
          checks++;
          if (rsp_valid !== term_flag) begin
            errors++;
            $display("FAIL rsp_latency: rsp_valid_o=%b, expected %b at cycle %0d", rsp_valid, term_flag, mcyc);
          end
        end
        if (rsp_valid === 1'b1) begin
          rsp_seen++;
          rsp_log.push_back(mcyc);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got err=%b rdata=%h, expected no response", rsp_err, rsp_rdata);
          end else begin
            me = exp_q.pop_front();
            if (rsp_err !== me.err || (me.chk && rsp_rdata !== me.rdata)) begin
              errors++;
              $display("FAIL rsp_data: got err=%b rdata=%h, expected err=%b rdata=%h", rsp_err, rsp_rdata, me.err, me.rdata);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wd, input int kind, input logic [31:0] rd, output int waited);
    exp_t e;
    plan_q.push_back('{kind, rd});
    e.err   = (kind != 0);
    e.chk   = !(kind == 0 && we);
    e.rdata = (kind == 0) ? rd : 32'h0;
    exp_q.push_back(e);
    @(negedge clk); #2;
    req_valid = 1; req_we = we; req_addr = addr; req_sel = sel; req_wdata = wd;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 40) begin
      @(negedge clk); #2;
      waited++;
    end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_ready: req_ready_o=%b after %0d cycles, expected 1", req_ready, waited);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); #3;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d responses missing, expected 0", name, exp_q.size());
    end
    checks++;
    if (wb.cyc !== 1'b0) begin
      errors++;
      $display("FAIL %s_cyc_end: cyc=%b in last response cycle, expected 0", name, wb.cyc);
    end
  endtask

  task automatic test_reset();
    rstn = 0; req_valid = 0; req_we = 0; req_addr = '0; req_sel = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wb.cyc, wb.stb, wb.we, wb.lock} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: cyc,stb,we,lock=%b, expected 0000", {wb.cyc, wb.stb, wb.we, wb.lock});
    end
    checks++;
    if ({wb.addr, wb.sel, wb.wdata} !== 68'h0) begin
      errors++; $display("FAIL reset_bus: addr=%h sel=%h wdata=%h, expected 0", wb.addr, wb.sel, wb.wdata);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      errors++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h, expected 0", rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if (dut.cnt !== '0 || dut.state !== IDLE) begin
      errors++; $display("FAIL reset_state: cnt=%0d state=%0d, expected 0 and IDLE", dut.cnt, dut.state);
    end
    #2 rstn = 1;
    @(negedge clk); #2;
    checks++;
    if (req_ready !== 1'b1 || wb.cyc !== 1'b0) begin
      errors++; $display("FAIL reset_idle: ready=%b cyc=%b, expected 1 and 0", req_ready, wb.cyc);
    end
  endtask

  task automatic test_single_read();
    int w, n0;
    slv_delay = 2;
    n0 = issue_cnt;
    send(0, 32'h1000, 4'hF, 32'h0, 0, 32'hDEADBEEF, w);
    drain("single");
    checks++;
    if (issue_cnt - n0 != 1) begin
      errors++; $display("FAIL single_stb: %0d strobes issued, expected 1", issue_cnt - n0);
    end
  endtask

  task automatic test_back_to_back();
    int w, i0;
    slv_delay = 3;
    i0 = issue_log.size();
    for (int i = 0; i < 4; i++) begin
      send(1, 32'h3000 + 32'(4 * i), 4'hF, 32'hA5A50000 + 32'(i), 0, 32'h0, w);
      checks++;
      if (w != 0) begin
        errors++; $display("FAIL b2b_accept%0d: waited %0d cycles, expected 0", i, w);
      end
    end
    send(0, 32'h3010, 4'h1, 32'h0, 0, 32'h5555AAAA, w);
    checks++;
    if (w != 1) begin
      errors++; $display("FAIL b2b_credit: fifth request waited %0d cycles, expected 1", w);
    end
    drain("b2b");
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (issue_log[i0 + k + 1] != issue_log[i0 + k] + 1) begin
        errors++; $display("FAIL b2b_stb_gap%0d: strobe at %0d, expected %0d", k, issue_log[i0 + k + 1], issue_log[i0 + k] + 1);
      end
    end
  endtask

  task automatic test_stall();
    int w, n0, t0;
    slv_delay = 2;
    stall_idx = issue_cnt + 1; stall_len = 3; t0 = stall_total; stall_moves = 0;
    n0 = issue_cnt; cnt_peak = 0;
    send(0, 32'h2000, 4'h3, 32'h12345678, 0, 32'h11112222, w);
    send(0, 32'h2004, 4'hC, 32'h9ABCDEF0, 0, 32'h33334444, w);
    drain("stall");
    stall_idx = -1;
    checks++;
    if (stall_total - t0 != 3) begin
      errors++; $display("FAIL stall_hold: stb held through %0d stall cycles, expected 3", stall_total - t0);
    end
    checks++;
    if (stall_moves != 0) begin
      errors++; $display("FAIL stall_stable: bus fields changed %0d times, expected 0", stall_moves);
    end
    checks++;
    if (issue_cnt - n0 != 2) begin
      errors++; $display("FAIL stall_issue: %0d issues, expected 2", issue_cnt - n0);
    end
    checks++;
    if (cnt_peak != 2) begin
      errors++; $display("FAIL stall_peak: cnt peaked at %0d, expected 2", cnt_peak);
    end
  endtask

  task automatic test_error();
    int w;
    slv_delay = 2;
    send(0, 32'h5000, 4'hF, 32'h0, 0, 32'hCAFE0001, w);
    send(0, 32'h5004, 4'hF, 32'h0, 1, 32'hBADBAD00, w);
    send(0, 32'h5008, 4'hF, 32'h0, 0, 32'hCAFE0003, w);
    drain("error");
    send(0, 32'h500C, 4'hF, 32'h0, 2, 32'h77778888, w);
    drain("retry");
  endtask

  task automatic test_stray_ack();
    int r0;
    r0 = rsp_seen;
    @(negedge clk); #2 spurious = 1;
    @(negedge clk); #2 spurious = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_seen != r0 || dut.cnt !== '0) begin
      errors++; $display("FAIL stray_ack: %0d responses, cnt=%0d, expected 0 and 0", rsp_seen - r0, dut.cnt);
    end
  endtask

  task automatic test_reset_mid();
    int w, r0;
    slv_delay = 10;
    send(0, 32'h4000, 4'hF, 32'h0, 0, 32'h01010101, w);
    send(0, 32'h4004, 4'hF, 32'h0, 0, 32'h02020202, w);
    checks++;
    if (dut.cnt !== 3'd2 || wb.stb !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: cnt=%0d stb=%b, expected 2 and 1", dut.cnt, wb.stb);
    end
    rstn = 0;
    exp_q.delete(); plan_q.delete();
    #1;
    checks++;
    if ({wb.cyc, wb.stb, rsp_valid} !== 3'b0) begin
      errors++; $display("FAIL rstmid_async: cyc,stb,rsp_valid=%b, expected 000", {wb.cyc, wb.stb, rsp_valid});
    end
    repeat (2) @(negedge clk);
    #2 rstn = 1;
    r0 = rsp_seen;
    repeat (15) @(negedge clk);
    checks++;
    if (rsp_seen != r0) begin
      errors++; $display("FAIL rstmid_lost: %0d responses after reset, expected 0", rsp_seen - r0);
    end
    slv_delay = 2;
    send(0, 32'h4008, 4'hF, 32'h0, 0, 32'h0BADF00D, w);
    drain("rstmid_next");
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    int w, r0;
    check_lat = 0; slv_delay = 2;
    cyc_rise = -1; cyc_fall = -1;
    r0 = rsp_log.size();
    send(0, 32'h6000, 4'hF, 32'h0, 3, 32'h0, w);
    send(0, 32'h6004, 4'hF, 32'h0, 3, 32'h0, w);
    drain("timeout");
    checks++;
    if (cyc_fall - cyc_rise != 8) begin
      errors++; $display("FAIL timeout_cyc: cyc high %0d cycles, expected 8", cyc_fall - cyc_rise);
    end
    checks++;
    if (rsp_log.size() < r0 + 2 || rsp_log[r0] != cyc_fall + 1 || rsp_log[r0 + 1] != rsp_log[r0] + 1) begin
      errors++; $display("FAIL timeout_pulses: %0d pulses, expected 2 on consecutive cycles after cyc fall", rsp_log.size() - r0);
    end
    checks++;
    if (dut.state !== IDLE || dut.cnt !== '0) begin
      errors++; $display("FAIL timeout_idle: state=%0d cnt=%0d, expected IDLE and 0", dut.state, dut.cnt);
    end
    slv_q.delete();
    check_lat = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall();
    test_error();
    test_stray_ack();
    test_reset_mid();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
